// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, sequences IDLE/RUN/DONE and resolves
// branch-not-equal-zero through a small programmable absolute-target table.
module fetch_unit #(
  parameter int PC_W      = 10,
  parameter int INSTR_W   = 9,
  parameter int LUT_DEPTH = 8,
  parameter int LUT_AW    = 3,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF,
  parameter int CNT_W     = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [INSTR_W-1:0] Instr_in,
  input  logic               Branch_en,
  input  logic               Zero,
  input  logic [LUT_AW-1:0]  Branch_idx,
  input  logic               Lut_we,
  input  logic [LUT_AW-1:0]  Lut_addr,
  input  logic [PC_W-1:0]    Lut_data,
  output logic [PC_W-1:0]    PC_out,
  output logic [2:0]         Opcode,
  output logic               Running,
  output logic               Done,
  output logic [CNT_W-1:0]   Cycle_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [PC_W-1:0]  pc_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic [PC_W-1:0]  lut [LUT_DEPTH];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      PC_out    <= '0;
      Cycle_cnt <= '0;
    end else begin
      state     <= state_nx;
      PC_out    <= pc_nx;
      Cycle_cnt <= cnt_nx;
    end
  end

  // Nonblocking write keeps a same-edge branch on the old entry.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
    end else if (Lut_we) begin
      lut[Lut_addr] <= Lut_data;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = PC_out;
    cnt_nx   = Cycle_cnt;
    case (state)
      IDLE: begin
        pc_nx = '0;
        if (Start) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        cnt_nx = (Cycle_cnt == '1) ? Cycle_cnt : Cycle_cnt + CNT_W'(1);
        if (Instr_in == HALT_INSTR) state_nx = DONE;
        else if (Branch_en && !Zero) pc_nx = lut[Branch_idx];
        else pc_nx = PC_out + PC_W'(1);
      end
      DONE: begin
        if (Start) begin
          state_nx = RUN;
          pc_nx    = '0;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Running = (state == RUN);
    Done    = (state == DONE);
    Opcode  = (state == RUN) ? Instr_in[INSTR_W-1 -: 3] : 3'b000;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a ROM image and a behavioural model of
// the run/halt/branch rules predict PC, state flags and cycle count each edge.
module tb_fetch_unit;

  localparam logic [8:0] HALT = 9'h1FF;

  logic       Clk, Reset, Start, Branch_en, Zero, Lut_we;
  logic [8:0] Instr_in;
  logic [2:0] Branch_idx, Lut_addr, Opcode;
  logic [9:0] Lut_data, PC_out;
  logic       Running, Done;
  logic [15:0] Cycle_cnt;

  int checks = 0;
  int errors = 0;

  logic [8:0] rom_instr [1024];
  bit         rom_br    [1024];
  bit         rom_z     [1024];
  logic [2:0] rom_idx   [1024];

  bit          m_run, m_done;
  int unsigned m_pc, m_cnt;
  int unsigned m_lut [8];

  fetch_unit #(
    .PC_W(10), .INSTR_W(9), .LUT_DEPTH(8), .LUT_AW(3),
    .HALT_INSTR(9'h1FF), .CNT_W(16)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instr_in(Instr_in),
    .Branch_en(Branch_en), .Zero(Zero), .Branch_idx(Branch_idx),
    .Lut_we(Lut_we), .Lut_addr(Lut_addr), .Lut_data(Lut_data),
    .PC_out(PC_out), .Opcode(Opcode), .Running(Running), .Done(Done),
    .Cycle_cnt(Cycle_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
    for (int i = 0; i < 8; i++) m_lut[i] = 0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    model_reset();
    #2;
    Reset = 1'b0;
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 1024; i++) begin
      rom_instr[i] = 9'($urandom_range(0, 510));
      rom_br[i]    = 0;
      rom_z[i]     = 1'($urandom_range(0, 1));
      rom_idx[i]   = 3'($urandom_range(0, 7));
    end
  endtask

  // One clock: present ROM word at PC_out, predict the edge, commit after it.
  task automatic tick(input bit start, input bit we, input logic [2:0] waddr,
                      input logic [9:0] wdata);
    int unsigned a, n_pc, n_cnt;
    bit n_run, n_done;
    a = PC_out;
    Start = start; Lut_we = we; Lut_addr = waddr; Lut_data = wdata;
    Instr_in = rom_instr[a]; Branch_en = rom_br[a]; Zero = rom_z[a];
    Branch_idx = rom_idx[a];
    n_pc = m_pc; n_cnt = m_cnt; n_run = m_run; n_done = m_done;
    if (m_run) begin
      if (m_cnt < 65535) n_cnt = m_cnt + 1;
      if (Instr_in == HALT) begin
        n_run = 0; n_done = 1;
      end else if (Branch_en && !Zero) begin
        n_pc = m_lut[Branch_idx];
      end else begin
        n_pc = (m_pc + 1) % 1024;
      end
    end else if (start) begin
      n_run = 1; n_done = 0; n_pc = 0; n_cnt = 0;
    end
    if (we) m_lut[waddr] = wdata;
    @(posedge Clk);
    #1;
    m_pc = n_pc; m_cnt = n_cnt; m_run = n_run; m_done = n_done;
    @(negedge Clk);
    Start = 1'b0;
    Lut_we = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    if (PC_out !== 10'd0 || Running !== 1'b0 || Done !== 1'b0 || Cycle_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state got pc=%h run=%b done=%b cnt=%0d exp 0/0/0/0",
               PC_out, Running, Done, Cycle_cnt);
    end
    checks++;
    Reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      Instr_in = 9'($urandom_range(0, 511));
      #1;
      if (Opcode !== 3'b000) begin
        errors++;
        $display("FAIL idle_opcode got %b exp 000", Opcode);
      end
      checks++;
    end
    @(negedge Clk);
  endtask

  task automatic test_straight();
    logic [8:0] w;
    fill_linear();
    rom_instr[5] = HALT;
    tick(1, 0, 0, 0);
    if (Running !== 1'b1 || PC_out !== 10'd0 || Cycle_cnt !== 16'd0) begin
      errors++;
      $display("FAIL start got run=%b pc=%h cnt=%0d exp 1/000/0", Running, PC_out, Cycle_cnt);
    end
    checks++;
    w = rom_instr[0];
    Instr_in = w;
    #1;
    if (Opcode !== w[8:6]) begin
      errors++;
      $display("FAIL run_opcode got %b exp %b", Opcode, w[8:6]);
    end
    checks++;
    for (int k = 1; k <= 6; k++) begin
      tick(0, 0, 0, 0);
      if (PC_out !== 10'((k < 6) ? k : 5) || PC_out !== 10'(m_pc)) begin
        errors++;
        $display("FAIL straight_pc step %0d got %h exp %h", k, PC_out, 10'(m_pc));
      end
      checks++;
    end
    if (Done !== 1'b1 || Running !== 1'b0 || Cycle_cnt !== 16'd6) begin
      errors++;
      $display("FAIL straight_done got done=%b run=%b cnt=%0d exp 1/0/6", Done, Running, Cycle_cnt);
    end
    checks++;
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0);
    if (PC_out !== 10'd5 || Cycle_cnt !== 16'd6 || Done !== 1'b1) begin
      errors++;
      $display("FAIL done_hold got pc=%h cnt=%0d done=%b exp 005/6/1", PC_out, Cycle_cnt, Done);
    end
    checks++;
  endtask

  task automatic test_branch();
    do_reset();
    fill_linear();
    tick(0, 1, 3'd3, 10'h040);
    rom_br[2] = 1; rom_z[2] = 0; rom_idx[2] = 3'd3;
    rom_instr[10'h040] = HALT;
    tick(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0);
    if (PC_out !== 10'h040 || PC_out !== 10'(m_pc)) begin
      errors++;
      $display("FAIL branch_taken got %h exp 040", PC_out);
    end
    checks++;
    tick(0, 0, 0, 0);
    rom_z[2] = 1;
    rom_instr[5] = HALT;
    tick(1, 0, 0, 0);
    if (Running !== 1'b1 || Done !== 1'b0 || PC_out !== 10'd0 || Cycle_cnt !== 16'd0) begin
      errors++;
      $display("FAIL restart got run=%b done=%b pc=%h cnt=%0d exp 1/0/000/0",
               Running, Done, PC_out, Cycle_cnt);
    end
    checks++;
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0);
    if (PC_out !== 10'd3) begin
      errors++;
      $display("FAIL branch_not_taken got %h exp 003", PC_out);
    end
    checks++;
    for (int k = 0; k < 20 && !m_done; k++) tick(0, 0, 0, 0);
    if (Done !== 1'b1 || PC_out !== 10'd5) begin
      errors++;
      $display("FAIL halt_timeout got done=%b pc=%h exp 1/005", Done, PC_out);
    end
    checks++;
  endtask

  task automatic test_rbw();
    rom_z[2] = 0;
    rom_instr[10'h040] = 9'h012;
    rom_br[10'h040] = 1; rom_z[10'h040] = 0; rom_idx[10'h040] = 3'd3;
    rom_instr[10'h080] = HALT;
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 3'd3, 10'h080);
    if (PC_out !== 10'h040) begin
      errors++;
      $display("FAIL rbw_old_entry got %h exp 040", PC_out);
    end
    checks++;
    tick(0, 0, 0, 0);
    if (PC_out !== 10'h080) begin
      errors++;
      $display("FAIL rbw_new_entry got %h exp 080", PC_out);
    end
    checks++;
    tick(0, 0, 0, 0);
  endtask

  task automatic test_halt_wins();
    rom_instr[0] = HALT; rom_br[0] = 1; rom_z[0] = 0; rom_idx[0] = 3'd3;
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    if (Done !== 1'b1 || Running !== 1'b0 || PC_out !== 10'd0 || Cycle_cnt !== 16'd1) begin
      errors++;
      $display("FAIL halt_wins got done=%b run=%b pc=%h cnt=%0d exp 1/0/000/1",
               Done, Running, PC_out, Cycle_cnt);
    end
    checks++;
    tick(1, 0, 0, 0);
    if (Running !== 1'b1 || Done !== 1'b0 || PC_out !== 10'd0 || Cycle_cnt !== 16'd0) begin
      errors++;
      $display("FAIL restart_after_halt got run=%b done=%b pc=%h cnt=%0d exp 1/0/000/0",
               Running, Done, PC_out, Cycle_cnt);
    end
    checks++;
    tick(0, 0, 0, 0);
  endtask

  task automatic test_wrap_saturate();
    do_reset();
    fill_linear();
    tick(0, 1, 3'd5, 10'h3FF);
    rom_br[0] = 1; rom_z[0] = 0; rom_idx[0] = 3'd5;
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    if (PC_out !== 10'h3FF) begin
      errors++;
      $display("FAIL preload_3ff got %h exp 3ff", PC_out);
    end
    checks++;
    tick(0, 0, 0, 0);
    if (PC_out !== 10'h000) begin
      errors++;
      $display("FAIL pc_wrap got %h exp 000", PC_out);
    end
    checks++;
    for (int k = 0; k < 8; k++) begin
      tick(1'($urandom_range(0, 1)), 0, 0, 0);
      if (Running !== 1'b1 || PC_out !== 10'(m_pc) || Cycle_cnt !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL start_in_run got run=%b pc=%h cnt=%0d exp 1/%h/%0d",
                 Running, PC_out, Cycle_cnt, 10'(m_pc), m_cnt);
      end
      checks++;
    end
    for (int k = 0; k < 65540; k++) tick(0, 0, 0, 0);
    if (Cycle_cnt !== 16'hFFFF || Running !== 1'b1) begin
      errors++;
      $display("FAIL cnt_saturate got cnt=%h run=%b exp ffff/1", Cycle_cnt, Running);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    #2;
    Reset = 1'b1;
    #1;
    if (PC_out !== 10'd0 || Running !== 1'b0 || Done !== 1'b0 || Cycle_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_reset got pc=%h run=%b done=%b cnt=%0d exp 000/0/0/0",
               PC_out, Running, Done, Cycle_cnt);
    end
    checks++;
    #1;
    Reset = 1'b0;
    model_reset();
    @(negedge Clk);
    rom_instr[0] = 9'h0A5; rom_br[0] = 1; rom_z[0] = 0;
    rom_idx[0] = 3'($urandom_range(0, 7));
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    if (PC_out !== 10'd0 || Running !== 1'b1) begin
      errors++;
      $display("FAIL lut_cleared got pc=%h run=%b exp 000/1", PC_out, Running);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 1024; i++) begin
        rom_instr[i] = ($urandom_range(0, 99) < 2) ? HALT : 9'($urandom_range(0, 510));
        rom_br[i]    = ($urandom_range(0, 99) < 25);
        rom_z[i]     = 1'($urandom_range(0, 1));
        rom_idx[i]   = 3'($urandom_range(0, 7));
      end
      for (int k = 0; k < 400; k++) begin
        tick(($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 20),
             3'($urandom_range(0, 7)), 10'($urandom_range(0, 1023)));
        if (PC_out !== 10'(m_pc) || Running !== m_run || Done !== m_done ||
            Cycle_cnt !== 16'(m_cnt)) begin
          errors++;
          $display("FAIL random r%0d k%0d got pc=%h run=%b done=%b cnt=%0d exp %h/%b/%b/%0d",
                   r, k, PC_out, Running, Done, Cycle_cnt, 10'(m_pc), m_run, m_done, m_cnt);
        end
        checks++;
        if (Opcode !== (m_run ? Instr_in[8:6] : 3'b000)) begin
          errors++;
          $display("FAIL random_opcode got %b run=%b instr=%h", Opcode, m_run, Instr_in);
        end
        checks++;
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Instr_in = '0; Branch_en = 1'b0; Zero = 1'b0;
    Branch_idx = '0; Lut_we = 1'b0; Lut_addr = '0; Lut_data = '0;
    test_reset();
    test_straight();
    test_branch();
    test_rbw();
    test_halt_wins();
    test_wrap_saturate();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
